// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C init sequencer: FSM encoding, table markers, entry layout.
package i2c_pkg;

  localparam logic [7:0] END_MARKER   = 8'hFF;
  localparam logic [7:0] DELAY_MARKER = 8'hFE;

  // Table entry layout: {slave_address, register, data}
  localparam int unsigned FieldW  = 8;
  localparam int unsigned AddrLsb = 16;
  localparam int unsigned RegLsb  = 8;
  localparam int unsigned DataLsb = 0;

  typedef struct packed {
    logic [7:0] slave;
    logic [7:0] regaddr;
    logic [7:0] data;
  } entry_t;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StFetch   = 4'd1;
  localparam logic [3:0] StLatch   = 4'd2;
  localparam logic [3:0] StIssue   = 4'd3;
  localparam logic [3:0] StWait    = 4'd4;
  localparam logic [3:0] StGap     = 4'd5;
  localparam logic [3:0] StAdvance = 4'd6;
  localparam logic [3:0] StFinish  = 4'd7;
  localparam logic [3:0] StAbort   = 4'd8;

endpackage

// File: rtl/i2c_gap_timer.sv
// Loadable down-counter with a zero flag; times inter-transaction gaps and delay commands.
module i2c_gap_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a table of I2C register writes and hands each to the byte-write engine, with retry and gap.
// Optional: define I2C_SEQ_DELAY_EN to treat slave address 8'hFE entries as delay commands.
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned TABLE_AW   = 6,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 500,
  parameter int unsigned GAP_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [TABLE_AW-1:0] err_index,
  output logic [TABLE_AW-1:0] rom_addr,
  input  logic [23:0]         rom_data,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [7:0]          wr_addr,
  output logic [7:0]          wr_reg,
  output logic [7:0]          wr_data,
  input  logic                wr_done,
  input  logic                wr_nack
);

`ifdef I2C_SEQ_DELAY_EN
  localparam int unsigned CntW = (GAP_W > 32) ? GAP_W : 32;
`else
  localparam int unsigned CntW = GAP_W;
`endif
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  logic [3:0]          state_q, state_d;
  logic [3:0]          pending_q, pending_d;
  logic [TABLE_AW-1:0] index_q, index_d;
  logic [TABLE_AW-1:0] err_index_q, err_index_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  entry_t              entry_q, entry_d, rom_entry;
  logic                error_q, error_d;
  logic                timer_load, timer_zero;
  logic [CntW-1:0]     timer_value;
  logic                gap_go;
  logic [3:0]          gap_target;

  assign rom_entry = '{slave:   rom_data[AddrLsb +: FieldW],
                       regaddr: rom_data[RegLsb +: FieldW],
                       data:    rom_data[DataLsb +: FieldW]};

`ifdef I2C_SEQ_DELAY_EN
  logic [31:0] delay_cycles;
  assign delay_cycles = {16'd0, rom_entry.regaddr, rom_entry.data} * GAP_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    index_d     = index_q;
    err_index_d = err_index_q;
    retry_d     = retry_q;
    entry_d     = entry_q;
    error_d     = error_q;
    timer_load  = 1'b0;
    timer_value = '0;
    gap_go      = 1'b0;
    gap_target  = StIdle;

    case (state_q)
      StIdle: begin
        if (start) begin
          error_d = 1'b0;
          index_d = '0;
          retry_d = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        entry_d = rom_entry;
        if (rom_entry.slave == END_MARKER) begin
          state_d = StFinish;
        end
`ifdef I2C_SEQ_DELAY_EN
        else if (rom_entry.slave == DELAY_MARKER) begin
          if (delay_cycles == '0) begin
            state_d = StAdvance;
          end else begin
            timer_load  = 1'b1;
            timer_value = CntW'(delay_cycles - 32'd1);
            pending_d   = StAdvance;
            state_d     = StGap;
          end
        end
`endif
        else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (wr_ready) state_d = StWait;
      end
      StWait: begin
        if (wr_done) begin
          if (!wr_nack) begin
            retry_d    = '0;
            gap_go     = 1'b1;
            gap_target = StAdvance;
          end else if (retry_q < RetryMax) begin
            retry_d    = retry_q + 1'b1;
            gap_go     = 1'b1;
            gap_target = StIssue;
          end else begin
            error_d     = 1'b1;
            err_index_d = index_q;
            state_d     = StAbort;
          end
        end
      end
      StGap: begin
        if (timer_zero) state_d = pending_q;
      end
      StAdvance: begin
        if (index_q == {TABLE_AW{1'b1}}) begin
          state_d = StFinish;
        end else begin
          index_d = index_q + 1'b1;
          state_d = StFetch;
        end
      end
      StFinish: state_d = StIdle;
      StAbort:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // The timer is loaded with N-1 so the GAP state lasts exactly N cycles; N=0 skips it.
    if (gap_go) begin
      pending_d = gap_target;
      if (GAP_CYCLES == 0) begin
        state_d = gap_target;
      end else begin
        timer_load  = 1'b1;
        timer_value = CntW'(GAP_CYCLES - 1);
        state_d     = StGap;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= StIdle;
      index_q     <= '0;
      err_index_q <= '0;
      retry_q     <= '0;
      entry_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      index_q     <= index_d;
      err_index_q <= err_index_d;
      retry_q     <= retry_d;
      entry_q     <= entry_d;
      error_q     <= error_d;
    end
  end

  i2c_gap_timer #(
    .W (CntW)
  ) u_gap_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  assign busy      = (state_q != StIdle) && (state_q != StFinish) && (state_q != StAbort);
  assign done      = (state_q == StFinish);
  assign error     = error_q;
  assign err_index = err_index_q;
  assign rom_addr  = index_q;
  assign wr_valid  = (state_q == StIssue);
  assign wr_addr   = entry_q.slave;
  assign wr_reg    = entry_q.regaddr;
  assign wr_data   = entry_q.data;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench for i2c_init_sequencer: expected writes and outcomes are queued per test
// and popped by a monitor whenever the DUT presents a command, done or error.
module tb_i2c_init_sequencer;

  localparam int unsigned TableAw   = 3;
  localparam int unsigned MaxRetry  = 3;
  localparam int unsigned GapCycles = 10;
  localparam int unsigned GapW      = 16;
  localparam int unsigned Depth     = 1 << TableAw;
  localparam logic [31:0] OutDone   = 32'h100;
  localparam logic [31:0] OutErr    = 32'h200;

  logic               clock;
  logic               reset;
  logic               start;
  logic               busy;
  logic               done;
  logic               error;
  logic [TableAw-1:0] err_index;
  logic [TableAw-1:0] rom_addr;
  logic [23:0]        rom_data;
  logic               wr_valid;
  logic               wr_ready;
  logic [7:0]         wr_addr;
  logic [7:0]         wr_reg;
  logic [7:0]         wr_data;
  logic               wr_done;
  logic               wr_nack;

  logic [23:0] rom [Depth];
  logic [23:0] exp_q[$];
  logic [31:0] out_q[$];
  bit          nack_q[$];
  int          ready_hold = 0;
  int          n_checks   = 0;
  int          n_pass     = 0;
  int          cyc        = 0;

  i2c_init_sequencer #(
    .TABLE_AW   (TableAw),
    .MAX_RETRY  (MaxRetry),
    .GAP_CYCLES (GapCycles),
    .GAP_W      (GapW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .wr_done   (wr_done),
    .wr_nack   (wr_nack)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous table ROM: data valid one cycle after the address.
  always_ff @(posedge clock) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Write engine: completes each accepted command 4 cycles later, NACK taken from nack_q.
  initial begin
    bit xfer;
    int lat;
    lat      = 0;
    wr_ready = 1'b0;
    wr_done  = 1'b0;
    wr_nack  = 1'b0;
    forever begin
      @(negedge clock);
      xfer = wr_valid && wr_ready;
      @(posedge clock);
      #1;
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (xfer) begin
        lat = 4;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          wr_done = 1'b1;
          wr_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        end
      end
      if (ready_hold > 0) begin
        wr_ready = 1'b0;
        ready_hold--;
      end else begin
        wr_ready = 1'b1;
      end
    end
  end

  // Monitor: compares commands, hold-while-not-ready, gaps and outcomes.
  initial begin
    bit          gap_flag;
    bit          pend;
    bit          err_prev;
    int          last_done;
    int          outstanding;
    logic [31:0] act;
    gap_flag = 0; pend = 0; err_prev = 0; last_done = 0; outstanding = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        gap_flag = 0; pend = 0; err_prev = 0; outstanding = 0;
      end else begin
        if (pend) check("wr_valid_held", 32'(wr_valid), 32'd1);
        if (wr_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_xfer", 32'({wr_addr, wr_reg, wr_data}));
          end else begin
            check("wr_fields", 32'({wr_addr, wr_reg, wr_data}), 32'(exp_q[0]));
            if (wr_ready) begin
              if (gap_flag) check("gap_cycles", 32'((cyc - last_done) > int'(GapCycles)), 32'd1);
              gap_flag = 0;
              void'(exp_q.pop_front());
              outstanding++;
            end
          end
        end
        pend = wr_valid && !wr_ready;
        if (wr_done && outstanding > 0) begin
          outstanding--;
          gap_flag  = 1;
          last_done = cyc;
        end
        if (done || (error && !err_prev)) begin
          act = done ? OutDone : (OutErr | 32'(err_index));
          if (done) check("done_busy_low", 32'(busy), 32'd0);
          if (out_q.size() == 0) fail_now("unexpected_outcome", act);
          else check("outcome", act, out_q.pop_front());
        end
        err_prev = error;
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < int'(Depth); i++) rom[i] = 24'hFFFFFF;
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Pulses start and counts cycles from the start cycle to the first wr_valid.
  task automatic start_latency(output int lat);
    pulse_start();
    lat = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (wr_valid) break;
      lat++;
    end
  endtask

  task automatic wait_end(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (done || error) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic end_test(input string name);
    repeat (3) @(negedge clock);
    check({name, "_xfers_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_outcomes_left"}, 32'(out_q.size()), 32'd0);
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
    check({name, "_err_index"}, 32'(err_index), 32'd0);
    check({name, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({name, "_wr_valid"}, 32'(wr_valid), 32'd0);
    check({name, "_wr_fields"}, 32'({wr_addr, wr_reg, wr_data}), 32'd0);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    start = 1'b0;
    clear_rom();

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // Two writes then end marker, always ACK; start while busy is ignored
    clear_rom();
    rom[0] = 24'h4210AA;
    rom[1] = 24'h421155;
    exp_q.push_back(24'h4210AA);
    exp_q.push_back(24'h421155);
    out_q.push_back(OutDone);
    start_latency(lat);
    check("start_latency", 32'(lat), 32'd3);
    pulse_start();
    wait_end(1000);
    check("basic_error", 32'(error), 32'd0);
    end_test("basic");

    // Entry 1 NACKs twice then ACKs
    nack_q = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_q  = '{24'h4210AA, 24'h421155, 24'h421155, 24'h421155};
    out_q.push_back(OutDone);
    pulse_start();
    wait_end(1000);
    check("retry_error", 32'(error), 32'd0);
    end_test("retry");

    // Entry 2 always NACKs: four issues then abort
    rom[2] = 24'h502033;
    nack_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_q  = '{24'h4210AA, 24'h421155, 24'h502033, 24'h502033, 24'h502033, 24'h502033};
    out_q.push_back(OutErr | 32'd2);
    pulse_start();
    wait_end(1000);
    end_test("abort");
    check("abort_error", 32'(error), 32'd1);
    check("abort_err_index", 32'(err_index), 32'd2);

    // wr_ready low for 20 cycles: command held steady; the new start clears error
    clear_rom();
    rom[0] = 24'h4210AA;
    rom[1] = 24'h421155;
    exp_q  = '{24'h4210AA, 24'h421155};
    out_q.push_back(OutDone);
    ready_hold = 20;
    pulse_start();
    @(negedge clock);
    check("restart_clears_error", 32'(error), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    wait_end(1000);
    end_test("ready_low");

    // Reset during WAIT, stale wr_done after reset must be ignored
    exp_q.push_back(24'h4210AA);
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (wr_valid && wr_ready) break;
    end
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_values("midreset");
    check("midreset_flushed", 32'(exp_q.size()), 32'd0);
    exp_q = '{24'h4210AA, 24'h421155};
    out_q.push_back(OutDone);
    @(posedge clock);
    #1 reset = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("restart_rom_addr", 32'(rom_addr), 32'd0);
    check("restart_busy2", 32'(busy), 32'd1);
    wait_end(1000);
    end_test("midreset");

    // 8'hFE entry: delay command when enabled, otherwise an ordinary write
    clear_rom();
    rom[0] = 24'hFE0004;
    rom[1] = 24'h4210AA;
`ifdef I2C_SEQ_DELAY_EN
    exp_q = '{24'h4210AA};
    out_q.push_back(OutDone);
    start_latency(lat);
    check("delay_latency", 32'(lat >= 43), 32'd1);
`else
    exp_q = '{24'hFE0004, 24'h4210AA};
    out_q.push_back(OutDone);
    start_latency(lat);
    check("fe_plain_latency", 32'(lat), 32'd3);
`endif
    wait_end(1000);
    end_test("fe_entry");

    // Full table with no end marker: all entries written, then done
    for (int i = 0; i < int'(Depth); i++) begin
      rom[i] = {8'h30, 8'(i), 8'(i) ^ 8'h5A};
      exp_q.push_back({8'h30, 8'(i), 8'(i) ^ 8'h5A});
    end
    out_q.push_back(OutDone);
    pulse_start();
    wait_end(2000);
    check("exhaust_error", 32'(error), 32'd0);
    end_test("exhaust");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Walks a table of I2C register writes (slave address, register, data) and issues each entry to the I2C byte-write engine through a valid/ready command handshake.
- Retries entries that are NACKed, inserts a programmable gap between transactions, and reports completion or failure.
- Sits between board bring-up logic (camera/codec/PMIC init) and the I2C write engine.

Parameters:
- TABLE_AW, 6, table address width; at most 2^TABLE_AW entries.
- MAX_RETRY, 3, retries per entry after the first NACK before aborting.
- GAP_CYCLES, 500, idle clock cycles between consecutive transactions, including retries.
- GAP_W, 16, width of the gap/delay counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins the sequence at entry 0
- busy  out  1  high from start acceptance until done or error
- done  out  1  one-cycle pulse; all entries written with ACK
- error  out  1  level; set on abort, cleared by the next start or by reset
- err_index  out  TABLE_AW  index of the failing entry
- rom_addr  out  TABLE_AW  table read address
- rom_data  in  24  {slave_address[23:16], register[15:8], data[7:0]}; valid 1 cycle after rom_addr
- wr_valid  out  1  command valid to the write engine
- wr_ready  in  1  engine can accept a command
- wr_addr, wr_reg, wr_data  out  8 each  command fields; stable while wr_valid is high
- wr_done  in  1  one-cycle pulse; transaction finished
- wr_nack  in  1  qualified by wr_done; 1 = any phase NACKed

Behaviour:
- Reset values: busy=0, done=0, error=0, err_index=0, rom_addr=0, wr_valid=0, wr_addr/wr_reg/wr_data=0. FSM goes to IDLE, index=0, retry=0. Reset overrides everything, including a transaction in flight. Any wr_done that arrives after reset is ignored.
- IDLE:
  - On start: clear error, set index=0, retry=0, busy=1, go to FETCH.
  - start while busy is ignored.
- FETCH: drive rom_addr=index; next cycle go to LATCH.
- LATCH:
  - Register rom_data.
  - If slave_address==8'hFF (end marker) go to FINISH.
  - Otherwise go to ISSUE.
- ISSUE:
  - wr_valid=1 with the latched fields.
  - Transfer occurs in a cycle where wr_valid and wr_ready are both high; drop wr_valid the next cycle and go to WAIT.
  - wr_valid never deasserts before the transfer.
- WAIT: wait for wr_done.
  - wr_nack=0: retry=0, load the gap counter, next state = ADVANCE.
  - wr_nack=1 and retry<MAX_RETRY: retry+1, load the gap counter, next state = ISSUE (same entry).
  - wr_nack=1 and retry==MAX_RETRY: go to ABORT.
- GAP: count GAP_CYCLES down to 0, then go to the pending next state. GAP_CYCLES=0 means zero extra cycles.
- ADVANCE:
  - If index == 2^TABLE_AW−1, go to FINISH (table exhausted with no marker is a success).
  - Otherwise index+1, go to FETCH.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- ABORT: error=1, err_index=index, busy=0, go to IDLE. done is not pulsed.
- Latency: start to the first wr_valid = 3 cycles (FETCH, LATCH, ISSUE).
- done and start in the same cycle: done completes first; start is honoured in IDLE on a later pulse only.

Optional Feature:
- Macro: I2C_SEQ_DELAY_EN.
- Defined: an entry with slave_address==8'hFE is a delay command. Wait {register,data}×GAP_CYCLES cycles (32-bit counter), no bus transaction, then ADVANCE. A value of 0 means no delay.
- Undefined: 8'hFE is sent as an ordinary write.

Decomposition:
- Shared package i2c_pkg:
  - FSM state encoding.
  - END_MARKER=8'hFF and DELAY_MARKER=8'hFE.
  - Entry field bit positions.
- Sub-module i2c_gap_timer: loadable down-counter with a zero flag, reused for the gap and the delay.

Test Plan:
- 3-entry table {0x42,0x10,0xAA},{0x42,0x11,0x55},{0xFF,..}, engine always ACKs -> exactly 2 wr_valid transfers with matching fields, done pulse, error=0, ≥GAP_CYCLES idle between transfers.
- Entry 1 NACKs twice then ACKs, MAX_RETRY=3 -> entry 1 issued 3 times, sequence completes with done.
- Entry 2 always NACKs -> 4 issues of entry 2, error=1, err_index=2, no done, busy=0.
- wr_ready held low 20 cycles -> wr_valid and fields stable throughout, single transfer once ready rises.
- Reset asserted in WAIT, then start -> all outputs at reset values, sequence restarts at rom_addr=0, stale wr_done ignored.
- I2C_SEQ_DELAY_EN, entry {0xFE,0x00,0x04}, GAP_CYCLES=10 -> ≥40 cycles with no wr_valid, then the next entry is issued.
